// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//   Bundles the signals between the memory arbiter, its two requesters
//   (instruction fetch and data access) and the shared single-port memory.
//
//   Signal groups:
//     if_*   : instruction-fetch requester (req/addr in, gnt/valid/rdata out)
//     dm_*   : data requester (req/we/addr/wdata in, gnt/valid/rdata/err out)
//     mem_*  : shared memory port (en/we/addr/wdata out, rdata in)
//     busy   : arbiter is in a response state
//
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (requesters and memory)
// -----------------------------------------------------------------------------
interface memory_arbiter_if #(
   parameter int ADDR_W = 12
);
   // Instruction-fetch side
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [31:0]       if_rdata;

   // Data side
   logic              dm_req;
   logic              dm_we;
   logic [31:0]       dm_addr;
   logic [31:0]       dm_wdata;
   logic              dm_gnt;
   logic              dm_valid;
   logic [31:0]       dm_rdata;
   logic              dm_err;

   // Shared memory side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_valid, if_rdata,
      output dm_gnt, dm_valid, dm_rdata, dm_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_valid, if_rdata,
      input  dm_gnt, dm_valid, dm_rdata, dm_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-port synchronous memory (4*2^ADDR_W bytes) between an
//   instruction-fetch port and a data port. A request is granted combinationally
//   while idle; the memory answers one cycle later, when the arbiter presents
//   the valid pulse. One access per two cycles.
//
//   Arbitration: data wins a simultaneous request unless the fetch port was
//   passed over on the previous contested grant (starve flag), which makes
//   continuous contention alternate dm, if, dm, if ...
//
//   Misaligned data accesses (dm_addr[1:0] != 0) are granted without touching
//   memory and are answered with dm_valid + dm_err.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous, active-high reset; also masks grants and responses
//     bus  : memory_arbiter_if.slave (requesters, memory port, busy)
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int ADDR_W = 12
) (
   input  logic            clk,
   input  logic            rst,
   memory_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_RESP = 2'd1,
      DM_RESP = 2'd2,
      DM_ERR  = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   starve_q, starve_d;    // fetch lost the last contested grant
   logic   dm_load_q, dm_load_d;  // in-flight data access is a load

   logic   grant_if;
   logic   grant_dm;
   logic   dm_aligned;
   logic   dm_mem;                // data grant that actually reaches memory

   // Address bits the word-addressed memory never sees.
   logic   unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                               bus.dm_addr[31:ADDR_W+2]};

   assign dm_aligned = (bus.dm_addr[1:0] == 2'b00);

   // Grant decision: only from IDLE, never while reset is asserted.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (!rst && (state_q == IDLE)) begin
         if (bus.dm_req && !(bus.if_req && starve_q)) begin
            grant_dm = 1'b1;
         end else if (bus.if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   assign dm_mem = grant_dm & dm_aligned;

   // Next state: every response state lasts exactly one cycle.
   always_comb begin
      state_d   = IDLE;
      starve_d  = starve_q;
      dm_load_d = dm_load_q;
      if (grant_if) begin
         state_d  = IF_RESP;
         starve_d = 1'b0;
      end else if (grant_dm) begin
         state_d   = dm_aligned ? DM_RESP : DM_ERR;
         dm_load_d = ~bus.dm_we;
         if (bus.if_req) begin
            starve_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         starve_q  <= 1'b0;
         dm_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         dm_load_q <= dm_load_d;
      end
   end

   // Request side outputs
   assign bus.if_gnt   = grant_if;
   assign bus.dm_gnt   = grant_dm;

   // Memory port: quiet (all zero) unless an access is issued this cycle.
   assign bus.mem_en    = grant_if | dm_mem;
   assign bus.mem_we    = dm_mem & bus.dm_we;
   assign bus.mem_addr  = grant_if ? bus.if_addr[ADDR_W+1:2] :
                          dm_mem   ? bus.dm_addr[ADDR_W+1:2] : '0;
   assign bus.mem_wdata = dm_mem ? bus.dm_wdata : 32'h0;

   // Responses are suppressed while reset is asserted so an interrupted
   // access never produces a valid pulse; read data is zero without valid.
   assign bus.if_valid = !rst && (state_q == IF_RESP);
   assign bus.dm_valid = !rst && ((state_q == DM_RESP) || (state_q == DM_ERR));
   assign bus.dm_err   = !rst && (state_q == DM_ERR);
   assign bus.if_rdata = bus.if_valid ? bus.mem_rdata : 32'h0;
   assign bus.dm_rdata = (!rst && (state_q == DM_RESP) && dm_load_q) ?
                         bus.mem_rdata : 32'h0;

   assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed scenarios followed by randomized traffic against a transaction
//   level reference model. The bench also plays the shared memory: it samples
//   the memory command mid-cycle and returns registered read data after the
//   next rising edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   localparam int AW = 12;

   logic clk;
   logic rst;

   memory_arbiter_if #(.ADDR_W(AW)) bus ();

   memory_arbiter #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side memory contents (what the DUT actually wrote) and the
   // reference model's idea of the same memory.
   logic [31:0] mem     [logic [AW-1:0]];
   logic [31:0] ref_mem [logic [AW-1:0]];

   typedef enum {R_NONE, R_IF, R_DM, R_ERR} resp_e;

   // Power-up contents of a word that was never written.
   function automatic logic [31:0] seed(input logic [AW-1:0] w);
      return {w, 8'h5A, w};
   endfunction

   function automatic logic [31:0] mem_read(input logic [AW-1:0] w);
      return mem.exists(w) ? mem[w] : seed(w);
   endfunction

   function automatic logic [31:0] ref_read(input logic [AW-1:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : seed(w);
   endfunction

   // {if_gnt, dm_gnt, if_valid, dm_valid, dm_err, mem_en, mem_we, busy}
   function automatic logic [7:0] ctl();
      return {bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid,
              bus.dm_err, bus.mem_en, bus.mem_we, bus.busy};
   endfunction

   task automatic settle();
      #2;
   endtask

   // Called mid-cycle: serve the memory command, cross the rising edge,
   // then return to the next falling edge where new stimulus is applied.
   task automatic clock();
      logic [31:0] rd;
      rd = bus.mem_rdata;
      if (bus.mem_en === 1'b1) begin
         if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
         else                     rd = mem_read(bus.mem_addr);
      end
      @(posedge clk);
      #1 bus.mem_rdata = rd;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h1234_5678;
      @(negedge clk);
      settle();
      n_checks++;
      if (ctl() !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl(), 8'h00);
      end
      n_checks++;
      if ({bus.if_rdata, bus.dm_rdata, bus.mem_wdata} !== 96'h0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h expected all zero",
                            bus.if_rdata, bus.dm_rdata, bus.mem_wdata);
      end
      clock();
      rst = 1'b0;
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      settle();
      n_checks++;
      if (ctl() !== 8'h00) begin
         n_fail++; $display("FAIL idle_ctl: got %b expected %b", ctl(), 8'h00);
      end
      clock();
   endtask

   task automatic test_fetch();
      mem[12'd4] = 32'h0050_0093;
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
      settle();
      n_checks++;
      if (ctl() !== 8'b1000_0100) begin
         n_fail++; $display("FAIL fetch_gnt: got %b expected %b", ctl(), 8'b1000_0100);
      end
      n_checks++;
      if (bus.mem_addr !== 12'd4) begin
         n_fail++; $display("FAIL fetch_addr: got %0d expected 4", bus.mem_addr);
      end
      clock();
      bus.if_req = 1'b0;
      settle();
      n_checks++;
      if (ctl() !== 8'b0010_0001) begin
         n_fail++; $display("FAIL fetch_valid: got %b expected %b", ctl(), 8'b0010_0001);
      end
      n_checks++;
      if (bus.if_rdata !== 32'h0050_0093) begin
         n_fail++; $display("FAIL fetch_rdata: got %h expected 00500093", bus.if_rdata);
      end
      clock();
      settle();
      n_checks++;
      if (bus.if_rdata !== 32'h0) begin
         n_fail++; $display("FAIL fetch_rdata_idle: got %h expected 0", bus.if_rdata);
      end
      clock();
   endtask

   task automatic test_store_load();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'hDEAD_BEEF;
      settle();
      n_checks++;
      if (ctl() !== 8'b0100_0110) begin
         n_fail++; $display("FAIL store_gnt: got %b expected %b", ctl(), 8'b0100_0110);
      end
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata} !== {12'd8, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL store_cmd: got addr %0d data %h expected addr 8 data deadbeef",
                            bus.mem_addr, bus.mem_wdata);
      end
      clock();
      bus.dm_req = 1'b0;
      settle();
      n_checks++;
      if (ctl() !== 8'b0001_0001) begin
         n_fail++; $display("FAIL store_valid: got %b expected %b", ctl(), 8'b0001_0001);
      end
      n_checks++;
      if (bus.dm_rdata !== 32'h0) begin
         n_fail++; $display("FAIL store_rdata: got %h expected 0", bus.dm_rdata);
      end
      n_checks++;
      if (mem_read(12'd8) !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL store_written: got %h expected deadbeef", mem_read(12'd8));
      end
      clock();
      // Load the word back.
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
      settle();
      n_checks++;
      if (ctl() !== 8'b0100_0100) begin
         n_fail++; $display("FAIL load_gnt: got %b expected %b", ctl(), 8'b0100_0100);
      end
      clock();
      bus.dm_req = 1'b0;
      settle();
      n_checks++;
      if ({ctl(), bus.dm_rdata} !== {8'b0001_0001, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL load_resp: got %b %h expected 00010001 deadbeef",
                            ctl(), bus.dm_rdata);
      end
      clock();
   endtask

   task automatic test_misaligned();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h22;
      settle();
      n_checks++;
      if (ctl() !== 8'b0100_0000) begin
         n_fail++; $display("FAIL misalign_gnt: got %b expected %b", ctl(), 8'b0100_0000);
      end
      clock();
      bus.dm_req = 1'b0;
      settle();
      n_checks++;
      if ({ctl(), bus.dm_rdata} !== {8'b0001_1001, 32'h0}) begin
         n_fail++; $display("FAIL misalign_resp: got %b %h expected 00011001 00000000",
                            ctl(), bus.dm_rdata);
      end
      clock();
   endtask

   task automatic test_wrap();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_4004;
      settle();
      n_checks++;
      if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 12'd1}) begin
         n_fail++; $display("FAIL wrap_addr: got gnt %b addr %0d expected gnt 1 addr 1",
                            bus.if_gnt, bus.mem_addr);
      end
      clock();
      bus.if_req = 1'b0;
      settle();
      n_checks++;
      if (bus.if_rdata !== seed(12'd1)) begin
         n_fail++; $display("FAIL wrap_rdata: got %h expected %h", bus.if_rdata, seed(12'd1));
      end
      clock();
   endtask

   task automatic test_reset_abort();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
      settle();
      n_checks++;
      if (bus.if_gnt !== 1'b1) begin
         n_fail++; $display("FAIL abort_gnt: got %b expected 1", bus.if_gnt);
      end
      clock();
      rst = 1'b1;
      settle();
      n_checks++;
      if (ctl() & 8'b1111_1110) begin
         n_fail++; $display("FAIL abort_no_valid: got %b expected 0000000x", ctl());
      end
      clock();
      rst = 1'b0;
      settle();
      n_checks++;
      if ({ctl(), bus.mem_addr} !== {8'b1000_0100, 12'd4}) begin
         n_fail++; $display("FAIL abort_regrant: got %b addr %0d expected 10000100 addr 4",
                            ctl(), bus.mem_addr);
      end
      clock();
      bus.if_req = 1'b0;
      settle();
      n_checks++;
      if ({ctl(), bus.if_rdata} !== {8'b0010_0001, 32'h0050_0093}) begin
         n_fail++; $display("FAIL abort_reissue: got %b %h expected 00100001 00500093",
                            ctl(), bus.if_rdata);
      end
      clock();
   endtask

   task automatic test_back_to_back();
      logic [71:0] exp;
      rst = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
      settle();
      clock();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         // Even cycles grant, odd cycles respond; dm first, then alternating.
         if (c % 2 == 0) exp = ((c / 2) % 2 == 0) ? {8'b0100_0100, 64'h0}
                                                  : {8'b1000_0100, 64'h0};
         else            exp = ((c / 2) % 2 == 0) ? {8'b0001_0001, 32'h0, 32'hDEAD_BEEF}
                                                  : {8'b0010_0001, 32'h0050_0093, 32'h0};
         settle();
         n_checks++;
         if ({ctl(), bus.if_rdata, bus.dm_rdata} !== exp) begin
            n_fail++; $display("FAIL b2b_cycle%0d: got %h expected %h",
                               c, {ctl(), bus.if_rdata, bus.dm_rdata}, exp);
         end
         clock();
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
   endtask

   task automatic test_random();
      resp_e          resp, resp_n;
      logic [31:0]    resp_data, resp_data_n;
      bit             if_passed, if_pend, dm_pend;
      logic [31:0]    ia, da, dw;
      logic           dwe;
      logic [AW-1:0]  w;
      logic [7:0]     e_ctl;
      logic [31:0]    e_ird, e_drd, e_wd, o_wd;
      logic [AW-1:0]  e_addr, o_addr;

      ref_mem   = mem;
      resp      = R_NONE;
      resp_data = 32'h0;
      if_passed = 1'b0;
      if_pend   = 1'b0;
      dm_pend   = 1'b0;
      ia = 32'h0; da = 32'h0; dw = 32'h0; dwe = 1'b0;

      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            ia      = $urandom;
         end
         if (!dm_pend && $urandom_range(0, 2) != 0) begin
            dm_pend = 1'b1;
            dwe     = 1'($urandom_range(0, 1));
            da      = $urandom;
            if ($urandom_range(0, 7) != 0) da[1:0] = 2'b00;
            dw      = $urandom;
         end
         bus.if_req   = if_pend;
         bus.if_addr  = if_pend ? ia : $urandom;
         bus.dm_req   = dm_pend;
         bus.dm_we    = dm_pend ? dwe : 1'($urandom_range(0, 1));
         bus.dm_addr  = dm_pend ? da : $urandom;
         bus.dm_wdata = dm_pend ? dw : $urandom;

         e_ctl = 8'h0; e_ird = 32'h0; e_drd = 32'h0; e_addr = '0; e_wd = 32'h0;
         resp_n = R_NONE; resp_data_n = 32'h0;
         case (resp)
            R_IF:  begin e_ctl = 8'b0010_0001; e_ird = resp_data; end
            R_DM:  begin e_ctl = 8'b0001_0001; e_drd = resp_data; end
            R_ERR: begin e_ctl = 8'b0001_1001; end
            default: begin
               if (if_pend && (!dm_pend || if_passed)) begin
                  w           = ia[AW+1:2];
                  e_ctl       = 8'b1000_0100;
                  e_addr      = w;
                  resp_n      = R_IF;
                  resp_data_n = ref_read(w);
                  if_passed   = 1'b0;
                  if_pend     = 1'b0;
               end else if (dm_pend) begin
                  if (if_pend) if_passed = 1'b1;
                  w = da[AW+1:2];
                  if (da[1:0] == 2'b00) begin
                     e_ctl  = {2'b01, 3'b000, 1'b1, dwe, 1'b0};
                     e_addr = w;
                     e_wd   = dw;
                     resp_n = R_DM;
                     if (dwe) ref_mem[w] = dw;
                     else     resp_data_n = ref_read(w);
                  end else begin
                     e_ctl  = 8'b0100_0000;
                     resp_n = R_ERR;
                  end
                  dm_pend = 1'b0;
               end
            end
         endcase

         settle();
         o_addr = e_ctl[2] ? bus.mem_addr : '0;
         o_wd   = (e_ctl[6] && e_ctl[2]) ? bus.mem_wdata : 32'h0;
         n_checks++;
         if ({ctl(), bus.if_rdata, bus.dm_rdata, o_addr, o_wd} !==
             {e_ctl, e_ird, e_drd, e_addr, e_wd}) begin
            n_fail++;
            $display("FAIL rand_cycle%0d: got ctl %b ird %h drd %h addr %h wd %h expected ctl %b ird %h drd %h addr %h wd %h",
                     cyc, ctl(), bus.if_rdata, bus.dm_rdata, o_addr, o_wd,
                     e_ctl, e_ird, e_drd, e_addr, e_wd);
         end
         clock();
         resp      = resp_n;
         resp_data = resp_data_n;
      end
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = 32'h0;
      bus.dm_wdata  = 32'h0;
      bus.mem_rdata = 32'h0;

      test_reset();
      test_fetch();
      test_store_load();
      test_misaligned();
      test_wrap();
      test_reset_abort();
      test_back_to_back();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
